// File: rtl/mem_port_arbiter_if.sv
// Bundle between the two-requester RAM arbiter and its surroundings:
// requester handshakes, shared read data and the single synchronous RAM port.
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_q;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
        output ack0, ack1, rdata, busy, ram_addr, ram_data, ram_we
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_q,
        input  ack0, ack1, rdata, busy, ram_addr, ram_data, ram_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one synchronous RAM port: IDLE -> ACCESS -> RESP,
// alternating priority under contention, one transaction every three cycles.
module mem_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  owner_q, owner_d;
    logic                  lat_we_q, lat_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
    logic                  ram_we_q, ram_we_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  win_c;

    // Winner index: prio breaks ties, a lone requester always wins.
    assign win_c = (bus.req0 && bus.req1) ? prio_q : !bus.req0;

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req0 || bus.req1) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are computed one cycle ahead of the state they belong to.
    always_comb begin
        prio_d     = prio_q;
        owner_d    = owner_q;
        lat_we_d   = lat_we_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        rdata_d    = rdata_q;
        ram_we_d   = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d    = win_c;
                    lat_we_d   = win_c ? bus.we1    : bus.we0;
                    ram_addr_d = win_c ? bus.addr1  : bus.addr0;
                    ram_data_d = win_c ? bus.wdata1 : bus.wdata0;
                    ram_we_d   = lat_we_d;
                end
            end
            ACCESS: begin
                ack0_d = !owner_q;
                ack1_d = owner_q;
            end
            RESP: begin
                prio_d = !owner_q;
                if (!lat_we_q) rdata_d = bus.ram_q;
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            lat_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            lat_we_q   <= lat_we_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.busy     = busy_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_data = ram_data_q;
    // Read data arrives from the RAM during RESP; forward it then, hold it afterwards.
    assign bus.rdata    = (state_q == RESP && !lat_we_q) ? bus.ram_q : rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transactions, per-requester expectation
// queues drained by an ack-driven monitor, behavioural synchronous RAM.
module tb_mem_port_arbiter;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          we;
        logic [DW-1:0] rd;
        int          due;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    int            ack_seq[$];
    int            n_cmp  = 0;
    int            n_bad  = 0;
    int            cyc    = 0;
    int            we_cnt = 0;
    logic [AW-1:0] we_addr;
    logic [DW-1:0] we_data;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Synchronous RAM, read-before-write, one cycle read latency.
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ack pops the owner's expectation and checks timing and rdata.
    always @(negedge clk) begin
        exp_t e;
        if (bus.ram_we) begin
            we_cnt++;
            we_addr = bus.ram_addr;
            we_data = bus.ram_data;
        end
        if (bus.ack0 || bus.ack1) begin
            check("ack_exclusive", 32'(bus.ack0 & bus.ack1), 32'd0);
            if (bus.ack0) begin
                ack_seq.push_back(0);
                if (q0.size() == 0) check("ack0_unexpected", 32'd1, 32'd0);
                else begin
                    e = q0.pop_front();
                    check("ack0_cycle", 32'(cyc), 32'(e.due));
                    check("ack0_rdata", 32'(bus.rdata), 32'(e.rd));
                end
            end
            if (bus.ack1) begin
                ack_seq.push_back(1);
                if (q1.size() == 0) check("ack1_unexpected", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    check("ack1_cycle", 32'(cyc), 32'(e.due));
                    check("ack1_rdata", 32'(bus.rdata), 32'(e.rd));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue one transaction, expect its ack lat cycles later, return one cycle after the ack.
    task automatic issue(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] rd, input int lat, input bit keep);
        exp_t e;
        bit   got;
        got   = 1'b0;
        e.we  = we;
        e.rd  = rd;
        e.due = cyc + lat;
        if (p == 0) begin
            q0.push_back(e);
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            q1.push_back(e);
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (p == 0) ? bus.ack0 : bus.ack1;
        end
        if (!got) begin
            check((p == 0) ? "ack0_timeout" : "ack1_timeout", 32'd0, 32'd1);
            if (p == 0 && q0.size() > 0) void'(q0.pop_back());
            if (p == 1 && q1.size() > 0) void'(q1.pop_back());
        end
        step(1);
        if (!keep) begin
            if (p == 0) bus.req0 = 1'b0;
            else        bus.req1 = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wc;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        mem[10'h010] = 16'hA010; mem[10'h020] = 16'hB020;
        mem[10'h030] = 16'hC030; mem[10'h040] = 16'hD040;
        mem[10'h050] = 16'hE050; mem[10'h060] = 16'hF060;
        mem[10'h071] = 16'h1171; mem[10'h072] = 16'h1172; mem[10'h073] = 16'h1173;
        reset    = 1'b1;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        step(3);
        reset = 1'b0;

        // Reset state
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_ack0",     32'(bus.ack0),     32'd0);
        check("rst_ack1",     32'(bus.ack1),     32'd0);
        check("rst_ram_we",   32'(bus.ram_we),   32'd0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_ram_data", 32'(bus.ram_data), 32'd0);
        check("rst_rdata",    32'(bus.rdata),    32'd0);

        // Contention from reset: requester 0 first, ack1 three cycles later
        ack_seq.delete();
        fork
            issue(0, 1'b0, 10'h010, 16'h0, 16'hA010, 2, 1'b0);
            issue(1, 1'b0, 10'h020, 16'h0, 16'hB020, 5, 1'b0);
        join
        check("cont_order_n", 32'(ack_seq.size()), 32'd2);
        if (ack_seq.size() == 2) begin
            check("cont_first",  32'(ack_seq[0]), 32'd0);
            check("cont_second", 32'(ack_seq[1]), 32'd1);
        end

        // Continuous contention: strict alternation 0,1,0,1
        ack_seq.delete();
        fork
            begin
                issue(0, 1'b0, 10'h030, 16'h0, 16'hC030, 2, 1'b1);
                issue(0, 1'b0, 10'h050, 16'h0, 16'hE050, 5, 1'b0);
            end
            begin
                issue(1, 1'b0, 10'h040, 16'h0, 16'hD040, 5, 1'b1);
                issue(1, 1'b0, 10'h060, 16'h0, 16'hF060, 5, 1'b0);
            end
        join
        check("alt_n", 32'(ack_seq.size()), 32'd4);
        if (ack_seq.size() == 4) begin
            check("alt_0", 32'(ack_seq[0]), 32'd0);
            check("alt_1", 32'(ack_seq[1]), 32'd1);
            check("alt_2", 32'(ack_seq[2]), 32'd0);
            check("alt_3", 32'(ack_seq[3]), 32'd1);
        end

        // Lone requester 1 with prio pointing at 0: served back-to-back
        issue(1, 1'b0, 10'h071, 16'h0, 16'h1171, 2, 1'b1);
        issue(1, 1'b0, 10'h072, 16'h0, 16'h1172, 2, 1'b1);
        issue(1, 1'b0, 10'h073, 16'h0, 16'h1173, 2, 1'b0);

        // Write then read on requester 0; write leaves rdata alone
        wc = we_cnt;
        issue(0, 1'b1, 10'h005, 16'hBEEF, 16'h1173, 2, 1'b0);
        check("wr_we_pulses", 32'(we_cnt - wc), 32'd1);
        check("wr_addr",      32'(we_addr),     32'h005);
        check("wr_data",      32'(we_data),     32'hBEEF);
        wc = we_cnt;
        issue(0, 1'b0, 10'h005, 16'h0, 16'hBEEF, 2, 1'b0);
        check("rd_we_pulses", 32'(we_cnt - wc), 32'd0);

        // Write on requester 1, read back on requester 0
        issue(1, 1'b1, 10'h3FF, 16'h1234, 16'hBEEF, 2, 1'b0);
        check("rdata_hold", 32'(bus.rdata), 32'hBEEF);
        issue(0, 1'b0, 10'h3FF, 16'h0, 16'h1234, 2, 1'b0);

        // Reset during ACCESS of a write: no ack, everything cleared
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 10'h100; bus.wdata0 = 16'h5555;
        step(1);
        check("abort_in_access", 32'(bus.ram_we), 32'd1);
        reset    = 1'b1;
        bus.req0 = 1'b0;
        step(1);
        reset = 1'b0;
        check("abort_ram_we",   32'(bus.ram_we),   32'd0);
        check("abort_busy",     32'(bus.busy),     32'd0);
        check("abort_rdata",    32'(bus.rdata),    32'd0);
        check("abort_ack0",     32'(bus.ack0),     32'd0);
        check("abort_ram_addr", 32'(bus.ram_addr), 32'd0);
        step(3);
        check("abort_idle_busy", 32'(bus.busy), 32'd0);

        // First arbitration after reset favours requester 0
        ack_seq.delete();
        fork
            issue(0, 1'b0, 10'h010, 16'h0, 16'hA010, 2, 1'b0);
            issue(1, 1'b0, 10'h020, 16'h0, 16'hB020, 5, 1'b0);
        join
        check("post_rst_n", 32'(ack_seq.size()), 32'd2);
        if (ack_seq.size() == 2) check("post_rst_first", 32'(ack_seq[0]), 32'd0);

        step(2);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, RAM word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, RAM word-address width in bits.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have ports req0/req1, input, 1 each, access request from requester 0/1.
REQ-007 The block SHALL have ports we0/we1, input, 1 each, 1 = write, 0 = read.
REQ-008 The block SHALL have ports addr0/addr1, input, ADDR_WIDTH each, word address.
REQ-009 The block SHALL have ports wdata0/wdata1, input, DATA_WIDTH each, write data.
REQ-010 The block SHALL have ports ack0/ack1, output, 1 each, one-cycle completion pulse.
REQ-011 The block SHALL have port rdata, output, DATA_WIDTH, registered read data, shared by both requesters.
REQ-012 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-013 The block SHALL have ports ram_addr (ADDR_WIDTH), ram_data (DATA_WIDTH) and ram_we (1), outputs, driving one port of the synchronous RAM.
REQ-014 The block SHALL have port ram_q, input, DATA_WIDTH, RAM read data, valid one clock after ram_addr is presented.

Function
REQ-015 The block SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-016 IDLE transitions:
- no req: stay in IDLE.
- any req: select a winner, latch its we/addr/wdata and owner index into internal registers, go to ACCESS.
REQ-017 Winner selection:
- only one req high: that requester wins.
- both high: requester indicated by the priority pointer prio wins.
REQ-018 ACCESS (one cycle):
- ram_addr and ram_data SHALL equal the latched addr and wdata.
- ram_we SHALL be 1 only if the latched we is 1.
- next state is RESP.
REQ-019 RESP (one cycle):
- ack of the owner SHALL be 1 and the other ack 0.
- for a read, rdata SHALL present the ram_q captured from the ACCESS address in that same cycle.
- prio SHALL be set to the non-owner.
- next state is IDLE.
REQ-020 ram_we SHALL be 0 in every state other than ACCESS. A write SHALL hit the RAM exactly once per transaction.
REQ-021 ram_addr and ram_data SHALL hold their last latched values outside ACCESS.
REQ-022 rdata SHALL hold its value until the next read's RESP. Write transactions SHALL NOT change rdata.
REQ-023 Requester protocol:
- a requester SHALL hold req, we, addr and wdata stable until its ack.
- a requester SHALL deassert req in the cycle after ack unless it issues a new request.
- a req seen in IDLE is always a new transaction.
REQ-024 Timing: latency from a req sampled in IDLE to ack SHALL be exactly 2 cycles. Throughput SHALL be one transaction per 3 cycles.
REQ-025 Fairness: with both requesters continuously requesting, grants SHALL strictly alternate. A lone requester SHALL be served back-to-back regardless of prio.
REQ-026 Req changes during ACCESS or RESP SHALL be ignored until the next IDLE.
REQ-027 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-028 When reset is high at a clock edge, the block SHALL enter IDLE with prio=0, ack0=ack1=0, busy=0, ram_we=0, ram_addr=0, ram_data=0, rdata=0 and latched registers cleared.
REQ-029 Reset asserted during ACCESS or RESP SHALL abort the transaction:
- no ack SHALL be issued.
- ram_we SHALL be 0 from the reset edge onward.
- the first post-reset arbitration SHALL favour requester 0.

Verification
REQ-030 Write, then read: req0 write addr 0x005, data 0xBEEF -> ram_we=1 for exactly one cycle with ram_addr=0x005, ack0 two cycles later. Then req0 read 0x005 -> ack0 with rdata=0xBEEF.
REQ-031 Contention: req0 and req1 both high from reset, reads of 0x010 and 0x020 -> ack0 first, then ack1, ack spacing 3 cycles, rdata correct for each.
REQ-032 Continuous contention for 12 cycles -> ack sequence 0,1,0,1. No cycle with both acks high.
REQ-033 Lone requester: req1 held high for 3 transactions -> three ack1 pulses 3 cycles apart, prio ignored.
REQ-034 Reset during ACCESS of a write -> no ack, ram_we=0 after the reset edge, busy=0, state IDLE, rdata=0.
REQ-035 Read after write on the other requester: req1 writes 0x3FF=0x1234, then req0 reads 0x3FF -> rdata=0x1234. The rdata value captured by an earlier read SHALL be unchanged by the intervening write.
